// File: rtl/fetch_stage.sv
// fetch_stage: keeps the program counter, issues one instruction-memory
// request at a time and buffers returned words in a 2-entry FIFO for the
// decode stage. A redirect flushes the buffer and restarts fetch at a new PC.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to make redirects to a
// non-word-aligned target be ignored and set a sticky fault flag. Without
// the macro, fault is tied low and redirect_pc is used as given.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (imem_req/imem_ack toward memory, instr_valid/instr_ready toward
// decode); a valid side holds its payload stable until that edge.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   redirect, redirect_pc   taken branch/jump and its target
//   imem_req, imem_addr     memory request and address (always the PC)
//   imem_ack, imem_rdata    memory accept with same-cycle instruction word
//   instr_valid, instr,     registered FIFO head toward decode
//   instr_pc, instr_ready
//   fault                   sticky misaligned-redirect flag
module fetch_stage #(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    input  logic         instr_ready,
    output logic         fault
);

    // REQ : request outstanding, FIFO has room
    // FULL: FIFO holds two entries, no request
    // DROP: a request is still outstanding but its data must be thrown away
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_FULL = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] pc;
    logic [N-1:0] pend_pc;

    // FIFO: slot 0 is always the head, slot 1 the entry behind it.
    logic         v0, v1;
    logic [N-1:0] pc0, pc1;
    logic [31:0]  in0, in1;

    logic redir_ok;
    logic push;
    logic pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    logic redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fault_q <= 1'b0;
        else if (redir_bad)
            fault_q <= 1'b1;
    end

    assign fault = fault_q;
`else
    assign redir_ok = redirect;
    assign fault    = 1'b0;
`endif

    // Held low during reset so no request is seen until reset is released.
    assign imem_req  = !reset && (state != S_FULL);
    assign imem_addr = pc;

    assign push = imem_req && imem_ack && (state == S_REQ) && !redir_ok;
    assign pop  = v0 && instr_ready;

    assign instr_valid = v0;
    assign instr       = in0;
    assign instr_pc    = pc0;

    // FIFO storage. A redirect empties it even if the head is popped in the
    // same cycle; the pop is still seen downstream through the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            pc0 <= '0;
            pc1 <= '0;
            in0 <= '0;
            in1 <= '0;
        end else if (redir_ok) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (push && pop) begin
            if (v1) begin
                pc0 <= pc1;
                in0 <= in1;
                pc1 <= pc;
                in1 <= imem_rdata;
            end else begin
                pc0 <= pc;
                in0 <= imem_rdata;
            end
        end else if (pop) begin
            pc0 <= pc1;
            in0 <= in1;
            v0  <= v1;
            v1  <= 1'b0;
        end else if (push) begin
            if (!v0) begin
                v0  <= 1'b1;
                pc0 <= pc;
                in0 <= imem_rdata;
            end else begin
                v1  <= 1'b1;
                pc1 <= pc;
                in1 <= imem_rdata;
            end
        end
    end

    // PC / request FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir_ok) begin
                        if (imem_ack) begin
                            pc <= redirect_pc;
                        end else begin
                            // Old request stays on the bus until acked.
                            pend_pc <= redirect_pc;
                            state   <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + N'(4);
                        // Occupancy was 1 and nothing leaves: now full.
                        if (v0 && !pop)
                            state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (redir_ok) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (pop) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redir_ok) begin
                        if (imem_ack) begin
                            pc    <= redirect_pc;
                            state <= S_REQ;
                        end else begin
                            pend_pc <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        pc    <= pend_pc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random
// stimulus, all checked every cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam int N = 64;
    localparam int W = N + 32;
    localparam logic [N-1:0] RST_PC = '0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         redirect = 1'b0;
    logic [N-1:0] redirect_pc = '0;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [N-1:0] instr_pc;
    logic         instr_ready = 1'b0;
    logic         fault;

    fetch_stage #(.N(N), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fault       (fault)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model: buffered {pc, instr} entries in order, the fetch PC,
    // whether the outstanding response must be dropped, and where to go then.
    logic [W-1:0] exp_q[$];
    logic [N-1:0] m_pc;
    logic [N-1:0] m_pend;
    bit           m_drop;
    bit           m_fault;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [N-1:0] a);
        return a[31:0] ^ 32'hA5A5A5A5;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc    = RST_PC;
        m_pend  = RST_PC;
        m_drop  = 0;
        m_fault = 0;
    endtask

    // Driver: one clock cycle. Inputs are applied at the falling edge,
    // outputs checked 1 time unit later, then the model advances to what the
    // DUT must hold after the next rising edge.
    task automatic step(input logic r, input logic [N-1:0] rpc, input logic ack_in, input logic rdy);
        bit           e_req, e_valid, ack_eff, pop_m, ok;
        logic [W-1:0] head;
        logic [31:0]  rd;
        @(negedge clk);
        e_req   = exp_q.size() < 2;
        e_valid = exp_q.size() > 0;
        ack_eff = ack_in && e_req;
        rd      = ack_eff ? mem_word(m_pc) : 32'($urandom);
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = ack_eff;
        imem_rdata  = rd;
        instr_ready = rdy;
        #1;
        check("imem_req", 64'(imem_req), 64'(e_req));
        if (e_req)
            check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("instr_valid", 64'(instr_valid), 64'(e_valid));
        if (e_valid) begin
            head = exp_q[0];
            check("instr_pc", 64'(instr_pc), 64'(head[W-1:32]));
            check("instr", 64'(instr), 64'(head[31:0]));
        end
        check("fault", 64'(fault), 64'(m_fault));

        pop_m = e_valid && rdy;
        ok    = r;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (r && rpc[1:0] != 2'b00) begin
            ok      = 0;
            m_fault = 1;
        end
`endif
        if (ok) begin
            exp_q.delete();
            if (!e_req || ack_eff) begin
                m_pc   = rpc;
                m_drop = 0;
            end else begin
                m_drop = 1;
                m_pend = rpc;
            end
        end else begin
            if (pop_m)
                void'(exp_q.pop_front());
            if (ack_eff) begin
                if (m_drop) begin
                    m_pc   = m_pend;
                    m_drop = 0;
                end else begin
                    exp_q.push_back({m_pc, rd});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    // Reset pulse of one cycle, checked while asserted.
    task automatic pulse_reset();
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(RST_PC));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stimulus
        logic [N-1:0] rpc;
        model_reset();
        repeat (3) @(posedge clk);
        pulse_reset();

        // Sequential fetch, full throughput
        repeat (6) step(0, '0, 1, 1);

        // Backpressure: fill, stall, then drain and resume
        repeat (4) step(0, '0, 1, 0);
        repeat (5) step(0, '0, 1, 1);

        // Redirect while request pending, ack withheld 3 cycles
        step(1, 64'h100, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        repeat (4) step(0, '0, 1, 1);

        // Two redirects while dropping: last one wins
        step(1, 64'h200, 0, 1);
        step(1, 64'h300, 0, 1);
        repeat (4) step(0, '0, 1, 1);

        // Redirect with same-cycle ack, and redirect while full
        step(1, 64'h400, 1, 1);
        repeat (3) step(0, '0, 1, 0);
        step(1, 64'h500, 1, 1);
        repeat (3) step(0, '0, 1, 1);

        // Wrap around the top of the address space
        step(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1);
        repeat (5) step(0, '0, 1, 1);

        // Misaligned redirect target
        step(1, 64'h102, 1, 1);
        repeat (4) step(0, '0, 1, 1);

        // Reset with two entries buffered
        repeat (4) step(0, '0, 1, 0);
        pulse_reset();
        repeat (4) step(0, '0, 1, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = {$urandom, $urandom} & ~64'h3;
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
                2:       rpc = 64'($urandom_range(0, 255) * 4);
                default: rpc = 64'($urandom_range(0, 1023));
            endcase
            step($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0)
                pulse_reset();
        end

        // Final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
